// File: rtl/alu_serial_seq_if.sv
// Handshake and result bus of the bit-serial ALU sequencer.
// The master issues operations; the slave (the sequencer) returns results and flags.
interface alu_serial_seq_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       overflow;
    logic [1:0] sel;
    logic [2:0] bit_idx;

    modport master (
        output start, a, b, op,
        input  busy, done, result, zero, overflow, sel, bit_idx
    );

    modport slave (
        input  start, a, b, op,
        output busy, done, result, zero, overflow, sel, bit_idx
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial 8-bit ALU sequencer: one operand bit per clock through a 1-bit slice,
// LSB first, returning result/zero/overflow with a one-cycle done pulse.
module alu_serial_seq (
    input logic             clk,
    input logic             rst,
    alu_serial_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state, state_next;
    logic [7:0] a_q, b_q, sr, result_q;
    logic [2:0] idx;
    logic [1:0] sel_q, sel_dec;
    logic       binvert, carry, op_valid, valid_dec;
    logic       zero_q, ovf_q;

    logic       ai, bb, s, cout, slice_bit, ovf7, final_ovf;
    logic [7:0] shifted, final_result;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (idx == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_dec   = 2'b00;
        valid_dec = 1'b1;
        case (bus.op)
            3'b000:          sel_dec = 2'b00;
            3'b001:          sel_dec = 2'b01;
            3'b010, 3'b110:  sel_dec = 2'b10;
            3'b111:          sel_dec = 2'b11;
            default:         valid_dec = 1'b0;
        endcase
    end

    // One slice of the ripple ALU; carry holds the carry into the current bit.
    always_comb begin
        ai   = a_q[idx];
        bb   = b_q[idx] ^ binvert;
        s    = ai ^ bb ^ carry;
        cout = (ai & bb) | (ai & carry) | (bb & carry);
        case (sel_q)
            2'b00:   slice_bit = ai & bb;
            2'b01:   slice_bit = ai | bb;
            2'b10:   slice_bit = s;
            default: slice_bit = 1'b0;
        endcase
        if (!op_valid) slice_bit = 1'b0;
        shifted = {slice_bit, sr[7:1]};
        ovf7    = carry ^ cout;

        final_result = shifted;
        final_ovf    = 1'b0;
        if (!op_valid) begin
            final_result = '0;
        end else if (sel_q == 2'b10) begin
            final_ovf = ovf7;
        end else if (sel_q == 2'b11) begin
            // SLT: sign of A-B, corrected when the subtraction overflowed
            final_result = {7'b0, s ^ ovf7};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sr       <= '0;
            idx      <= '0;
            sel_q    <= '0;
            binvert  <= 1'b0;
            carry    <= 1'b0;
            op_valid <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    a_q      <= bus.a;
                    b_q      <= bus.b;
                    sel_q    <= sel_dec;
                    op_valid <= valid_dec;
                    binvert  <= bus.op[2];
                    carry    <= bus.op[2];
                    idx      <= '0;
                    sr       <= '0;
                end
                RUN: begin
                    sr    <= shifted;
                    carry <= cout;
                    idx   <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        result_q <= final_result;
                        zero_q   <= (final_result == 8'h00);
                        ovf_q    <= final_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.sel      = sel_q;
    assign bus.bit_idx  = idx;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: expected results are queued at acceptance
// and compared when done pulses, together with latency and per-cycle protocol checks.
module tb_alu_serial_seq;
    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       ovf;
        logic [1:0] sel;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];
    logic [7:0] hold_res = 8'h00;
    int   busy_cnt = 0;

    alu_serial_seq_if bus ();

    alu_serial_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        logic [7:0] t;
        e.res = 8'h00; e.ovf = 1'b0; e.sel = 2'b00; e.acc = 0;
        case (op)
            3'b000: e.res = a & b;
            3'b001: begin e.res = a | b; e.sel = 2'b01; end
            3'b010: begin
                t = a + b; e.res = t; e.sel = 2'b10;
                e.ovf = (a[7] == b[7]) && (t[7] != a[7]);
            end
            3'b110: begin
                t = a - b; e.res = t; e.sel = 2'b10;
                e.ovf = (a[7] != b[7]) && (t[7] != a[7]);
            end
            3'b111: begin
                e.res = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00; e.sel = 2'b11;
            end
            default: ;
        endcase
        e.z = (e.res == 8'h00);
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check_eq("idle_timeout", {31'b0, bus.busy | bus.done}, 0);
    endtask

    // Drives one operation from IDLE, queues its expectation, then scrambles operands.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        wait_idle();
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.op = op;
        @(posedge clk); #1;
        e = model(a, b, op);
        e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 3'($urandom);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            check_eq("busy_and_done", {31'b0, bus.busy & bus.done}, 0);
            if (rst) begin
                busy_cnt = 0;
                hold_res = 8'h00;
            end else begin
                if (bus.busy) begin
                    check_eq("bit_idx", {29'b0, bus.bit_idx}, busy_cnt);
                    check_eq("result_hold", {24'b0, bus.result}, {24'b0, hold_res});
                    busy_cnt++;
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_done", {31'b0, bus.done}, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("result",   {24'b0, bus.result},   {24'b0, e.res});
                        check_eq("zero",     {31'b0, bus.zero},     {31'b0, e.z});
                        check_eq("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
                        check_eq("sel",      {30'b0, bus.sel},      {30'b0, e.sel});
                        check_eq("latency",  cyc - e.acc, 8);
                        check_eq("busy_cycles", busy_cnt, 8);
                        hold_res = e.res;
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] op; } vec_t;
    vec_t vecs[$] = '{
        '{8'hF0, 8'h3C, 3'b000}, '{8'hF0, 8'h3C, 3'b001},
        '{8'h7F, 8'h01, 3'b010}, '{8'hFF, 8'h01, 3'b010},
        '{8'h05, 8'h05, 3'b110}, '{8'h80, 8'h01, 3'b110},
        '{8'h80, 8'h01, 3'b111}, '{8'h01, 8'hFF, 3'b111},
        '{8'h22, 8'h22, 3'b111}, '{8'hA5, 8'h5A, 3'b011}
    };

    initial begin
        logic [2:0] ops [5];
        exp_t e;
        int n;
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",     {31'b0, bus.busy},     0);
        check_eq("rst_done",     {31'b0, bus.done},     0);
        check_eq("rst_result",   {24'b0, bus.result},   0);
        check_eq("rst_zero",     {31'b0, bus.zero},     1);
        check_eq("rst_overflow", {31'b0, bus.overflow}, 0);
        check_eq("rst_sel",      {30'b0, bus.sel},      0);
        check_eq("rst_bit_idx",  {29'b0, bus.bit_idx},  0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].op);
        for (int i = 0; i < 8; i++)
            run_op(8'($urandom), 8'($urandom), ops[$urandom_range(0, 4)]);

        // start held high: expect acceptances exactly 10 cycles apart
        wait_idle();
        bus.start = 1'b1; bus.a = 8'h3A; bus.b = 8'h5C; bus.op = 3'b010;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = model(8'h3A, 8'h5C, 3'b010);
            e.acc = cyc;
            sb.push_back(e);
            if (k < 2) repeat (9) @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;

        // reset in the middle of an ADD, then a clean rerun
        wait_idle();
        bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.op = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.busy && bus.bit_idx == 3'd4) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rst_wait_bit4", {29'b0, bus.bit_idx}, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy",   {31'b0, bus.busy},   0);
        check_eq("abort_done",   {31'b0, bus.done},   0);
        check_eq("abort_result", {24'b0, bus.result}, 0);
        check_eq("abort_zero",   {31'b0, bus.zero},   1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        run_op(8'h12, 8'h34, 3'b010);

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", sb.size(), 0);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
